// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART blocks
package uart_pkg;
    localparam int MIN_DIVISOR = 2;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        EVEN  = 3'd1,
        ODD   = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_mode_t;

    typedef enum logic [6:0] {
        IDLE   = 7'b000_0001,
        START  = 7'b000_0010,
        DATA   = 7'b000_0100,
        PARITY = 7'b000_1000,
        STOP   = 7'b001_0000,
        BREAK  = 7'b010_0000,
        MAB    = 7'b100_0000
    } uart_tx_state_t;

    function automatic logic [3:0] data_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter flagging the last cycle of each bit
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 bit_end
);
    logic [DIV_WIDTH-1:0] cnt;

    assign bit_end = cnt == divisor - DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt <= '0;
        else cnt <= (restart || bit_end) ? '0 : cnt + DIV_WIDTH'(1);
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with one-entry holding buffer and break
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_valid,
    input  logic [MAX_DATA_BITS-1:0] i_data,
    output logic                     o_ready,
    input  logic [DIV_WIDTH-1:0]     i_divisor,
    input  logic [1:0]               i_data_bits,
    input  logic [2:0]               i_parity,
    input  logic                     i_stop2,
    input  logic                     i_break,
    output logic                     o_busy,
    output logic                     o_tx
);
    uart_tx_state_t           state;
    parity_mode_t             par_mode;
    logic [MAX_DATA_BITS-1:0] buf_data, shreg;
    logic [DIV_WIDTH-1:0]     div_q, div_clamp;
    logic [2:0]               bit_cnt, last_idx;
    logic buf_valid, stop2, stop_cnt, par_acc, brk_done, bit_end;
    logic restart, last_stop, gap, go_break, go_start, par_x, par_bit;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk     (clk),
        .n_rst   (n_rst),
        .restart (restart),
        .divisor (div_q),
        .bit_end (bit_end)
    );

    // The counter is held at zero while idle or while a satisfied break waits for release,
    // so every state entry starts a fresh bit.
    always_comb begin
        div_clamp = i_divisor < DIV_WIDTH'(MIN_DIVISOR) ? DIV_WIDTH'(MIN_DIVISOR) : i_divisor;
        restart   = state == IDLE || (state == BREAK && brk_done);
        last_stop = state == STOP && bit_end && (!stop2 || stop_cnt);
        gap       = state == IDLE || last_stop || (state == MAB && bit_end);
        go_break  = i_break && (state == IDLE || last_stop);
        go_start  = gap && !go_break && buf_valid;
        par_x     = par_acc ^ shreg[0];
        par_bit   = par_mode == MARK ? 1'b1 : par_mode == SPACE ? 1'b0 : par_mode == ODD ? ~par_x : par_x;
    end

    assign o_ready = ~buf_valid;
    assign o_busy  = state != IDLE || buf_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            par_mode  <= NONE;
            buf_data  <= '0;
            shreg     <= '0;
            div_q     <= '0;
            bit_cnt   <= '0;
            last_idx  <= '0;
            buf_valid <= 1'b0;
            stop2     <= 1'b0;
            stop_cnt  <= 1'b0;
            par_acc   <= 1'b0;
            brk_done  <= 1'b0;
            o_tx      <= 1'b1;
        end else begin
            if (go_start) buf_valid <= 1'b0;
            else if (i_valid && !buf_valid) begin
                buf_valid <= 1'b1;
                buf_data  <= i_data;
            end
            if (go_start) begin
                state    <= START;
                o_tx     <= 1'b0;
                shreg    <= buf_data;
                div_q    <= div_clamp;
                last_idx <= 3'(data_bits(i_data_bits) - 4'd1);
                par_mode <= i_parity > 3'd4 ? NONE : parity_mode_t'(i_parity);
                stop2    <= i_stop2;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_acc  <= 1'b0;
            end else if (go_break) begin
                state    <= BREAK;
                o_tx     <= 1'b0;
                div_q    <= div_clamp;
                brk_done <= 1'b0;
            end else if (gap && state != IDLE) begin
                state <= IDLE;
                o_tx  <= 1'b1;
            end else begin
                case (state)
                    START: if (bit_end) begin
                        state <= DATA;
                        o_tx  <= shreg[0];
                    end
                    DATA: if (bit_end) begin
                        par_acc <= par_x;
                        if (bit_cnt == last_idx) begin
                            state <= par_mode == NONE ? STOP : PARITY;
                            o_tx  <= par_mode == NONE ? 1'b1 : par_bit;
                        end else begin
                            shreg   <= shreg >> 1;
                            o_tx    <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: if (bit_end) begin
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end
                    STOP: if (bit_end) stop_cnt <= 1'b1;
                    BREAK: begin
                        if (bit_end) brk_done <= 1'b1;
                        if ((brk_done || bit_end) && !i_break) begin
                            state <= MAB;
                            o_tx  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
